// File: rtl/shared_reg_arbiter_pkg.sv
// Shared constants for the two-requester register arbiter: state encoding
// and the width of the hold counter.
package shared_reg_arbiter_pkg;

  // FSM state encoding; one-hot across the two OWN states so each grant is a
  // single decoded bit of the state register.
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_OWN0 = 2'b01;
  localparam logic [1:0] ST_OWN1 = 2'b10;

  // Hold counter width; wide enough for HOLD_MAX up to 15.
  localparam int HOLD_W = 4;

endpackage : shared_reg_arbiter_pkg

// File: rtl/shared_reg_arbiter_dff_reg.sv
// WIDTH-bit bank of D flip-flops with a synchronous load enable and an
// asynchronous active-low clear to RESET_VAL.
module dff_reg
  import shared_reg_arbiter_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] data_q;

  // Load new data when enabled, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= RESET_VAL;
    end else if (en_i) begin
      // NOTE: sequential state uses non-blocking assignment so every flop
      // samples pre-edge values regardless of block evaluation order.
      data_q <= d_i;
    end
  end

  assign q_o = data_q;

endmodule : dff_reg

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter granting one of two requesters ownership of a shared
// WIDTH-bit register. An owner keeps the register while uncontested, but is
// forced to hand over after HOLD_MAX cycles if the other requester waits.
module shared_reg_arbiter
  import shared_reg_arbiter_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               HOLD_MAX  = 4,   // legal range 1..15
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             REQ0,
  input  logic             WE0,
  input  logic [WIDTH-1:0] WD0,
  input  logic             REQ1,
  input  logic             WE1,
  input  logic [WIDTH-1:0] WD1,
  output logic             GNT0,
  output logic             GNT1,
  output logic [WIDTH-1:0] Q,
  output logic             BUSY,
  output logic             LAST
);

  // Final count value before a contested owner must yield; also the
  // saturation point for an uncontested owner.
  localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(HOLD_MAX - 1);

  logic [1:0]        state_q, state_d;
  logic [HOLD_W-1:0] hold_q,  hold_d;
  logic              last_q,  last_d;
  logic              wr_en;
  logic [WIDTH-1:0]  wr_data;

  // Next-state, hold counter and last-grantee logic.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d = state_q;
    hold_d  = hold_q;
    last_d  = last_q;

    case (state_q)
      ST_IDLE: begin
        if (REQ0 && REQ1) state_d = last_q ? ST_OWN0 : ST_OWN1;
        else if (REQ0)    state_d = ST_OWN0;
        else if (REQ1)    state_d = ST_OWN1;
      end
      ST_OWN0: begin
        if (!REQ0)                         state_d = REQ1 ? ST_OWN1 : ST_IDLE;
        else if (REQ1 && hold_q == HOLD_LIM) state_d = ST_OWN1;
      end
      ST_OWN1: begin
        if (!REQ1)                         state_d = REQ0 ? ST_OWN0 : ST_IDLE;
        else if (REQ0 && hold_q == HOLD_LIM) state_d = ST_OWN0;
      end
      default: state_d = ST_IDLE;
    endcase

    // Entry into an OWN state (from IDLE or a direct handover) restarts the
    // hold count and records the new grantee; staying in OWN counts up and
    // saturates so an uncontested owner is never evicted.
    if (state_d != state_q && state_d != ST_IDLE) begin
      hold_d = '0;
      last_d = (state_d == ST_OWN1);
    end else if (state_q != ST_IDLE && hold_q != HOLD_LIM) begin
      hold_d = hold_q + HOLD_W'(1);
    end
  end

  // Arbiter state registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      hold_q  <= '0;
      last_q  <= 1'b1;   // requester 0 wins the first tie
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      last_q  <= last_d;
    end
  end

  // A write lands only from the current owner while it still requests,
  // which includes its final edge before a forced handover.
  assign wr_en   = ((state_q == ST_OWN0) && REQ0 && WE0) ||
                   ((state_q == ST_OWN1) && REQ1 && WE1);
  assign wr_data = (state_q == ST_OWN1) ? WD1 : WD0;

  dff_reg #(
    .WIDTH     (WIDTH),
    .RESET_VAL (RESET_VAL)
  ) u_reg (
    .clk   (CLK),
    .rst_n (RST_N),
    .en_i  (wr_en),
    .d_i   (wr_data),
    .q_o   (Q)
  );

  assign GNT0 = (state_q == ST_OWN0);
  assign GNT1 = (state_q == ST_OWN1);
  assign BUSY = GNT0 | GNT1;
  assign LAST = last_q;

endmodule : shared_reg_arbiter

// File: doc/shared_reg_arbiter.md
Name: shared_reg_arbiter

Overview:
- Arbitrates one WIDTH-bit storage register, built from DFF cells, between two requesters.
- Each requester uses a REQ/GNT handshake.
- Round-robin fairness, with a bounded hold time when the other requester is waiting.
- Sits between two datapath clients and the shared register bank; the register contents are always visible on Q.

Parameters:
- WIDTH, 8: data width of the shared register.
- HOLD_MAX, 4: maximum consecutive grant cycles while the other requester waits; legal range 1..15.
- RESET_VAL, 0: register contents after reset.

Ports:
- CLK  input  1  clock; all state changes on the rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- REQ0  input  1  requester 0 wants the register.
- WE0  input  1  requester 0 write enable; honoured only while granted.
- WD0  input  WIDTH  requester 0 write data.
- REQ1  input  1  requester 1 wants the register.
- WE1  input  1  requester 1 write enable; honoured only while granted.
- WD1  input  WIDTH  requester 1 write data.
- GNT0  output  1  requester 0 owns the register.
- GNT1  output  1  requester 1 owns the register.
- Q  output  WIDTH  current register contents.
- BUSY  output  1  high when either grant is high.
- LAST  output  1  index of the most recent grantee.

Behaviour:
- Reset (RST_N low, asynchronous, takes effect immediately, also mid-transaction):
  - state=IDLE; GNT0=GNT1=0; BUSY=0.
  - Q=RESET_VAL; LAST=1, so requester 0 wins the first tie; hold counter=0.
  - A write on the same edge as reset deassertion is lost.
- States: IDLE, OWN0, OWN1.
- Grants are Moore outputs: GNT0=(state==OWN0), GNT1=(state==OWN1). GNT0 and GNT1 are never both high.
- Grant latency: REQx sampled high at edge N puts GNTx high after edge N, at the earliest.
- IDLE transitions:
  - only REQ0 -> OWN0.
  - only REQ1 -> OWN1.
  - both -> OWN(~LAST).
  - none -> stay in IDLE.
- OWNx (x = owner, y = other requester):
  - REQx low at an edge -> OWNy if REQy is high, else IDLE.
  - REQx high, REQy high, and hold count == HOLD_MAX-1 -> OWNy (forced handover).
  - Otherwise stay in OWNx.
  - Direct OWNx -> OWNy handover takes no idle cycle.
- Hold counter:
  - cleared on entry to any OWN state.
  - incremented each edge spent in OWNx.
  - saturates at HOLD_MAX-1 while REQy is low, so an uncontested owner keeps the register indefinitely.
- LAST is updated to x on every entry to OWNx.
- Writes:
  - Q <= WDx at an edge where state==OWNx && REQx && WEx.
  - Q is visible the cycle after that edge.
  - WE from the non-granted requester is ignored.
  - A write on the owner's final edge is honoured when REQx is still high, including on a forced handover edge.
  - A write is not honoured when REQx has dropped.
- Requesters must hold REQ high until GNT is seen. A REQ pulse that drops before being granted is simply forgotten: no queued grant.
- All outputs are registered except BUSY, which is the OR of the grant registers.

Decomposition:
- Shared package holds:
  - state encoding constants ST_IDLE=2'b00, ST_OWN0=2'b01, ST_OWN1=2'b10.
  - counter width constant HOLD_W=4.
- Sub-module dff_reg (WIDTH, RESET_VAL): WIDTH DFF cells with synchronous load enable and async active-low clear to RESET_VAL.
  - The arbiter drives its load enable and its data mux (WD0/WD1 selected by owner).

Test Plan:
- Reset: RST_N=0 mid-OWN1 with WE1=1, WD1=8'hAA -> same cycle GNT1=0, Q=8'h00, LAST=1; after release with REQ0=REQ1=1, first grant goes to GNT0.
- Single requester write: REQ0=1 at edge 1, WE0=1, WD0=8'h5C at edge 2 -> GNT0=1 after edge 1, Q=8'h5C after edge 2, WE1=1/WD1=8'hFF in the same window leaves Q unchanged.
- Round-robin tie: REQ0=REQ1=1 continuously, HOLD_MAX=4 -> GNT0 for 4 cycles, GNT1 for 4 cycles, then GNT0 again, with no idle cycle between and BUSY constant 1.
- Uncontested hold: REQ1=1 alone for 20 cycles -> GNT1 stays high for all 20; REQ1 drop -> IDLE next edge, GNT1=0, LAST=1.
- Early release: OWN0 with REQ1 waiting, REQ0 drops after 2 cycles -> GNT1 high the next cycle; a WE0=1 on the drop edge does not change Q.
- Forced-handover write: on the HOLD_MAX-th edge in OWN0 with REQ0=REQ1=1, WE0=1, WD0=8'h3E -> Q=8'h3E and GNT1=1 after the same edge.
